// File: rtl/crack_pkg.sv
// ============================================================================
// Module   : crack_pkg
// Brief    : Shared state encoding and plaintext constants for crack_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_RUN      = 3'd2,
    ST_RD_LEN   = 3'd3,
    ST_WAIT_LEN = 3'd4,
    ST_SCAN     = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam logic [7:0] ASCII_LO = 8'h20;
  localparam logic [7:0] ASCII_HI = 8'h7E;
  localparam logic [7:0] LEN_ADDR = 8'd0;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crack_ctrl_if.sv
// ============================================================================
// Module   : crack_ctrl_if
// Brief    : Control, arc4-core and plaintext-memory signals of crack_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface crack_ctrl_if;
  logic        en;
  logic        rdy;
  logic        stop;
  logic        key_valid;
  logic [23:0] key_out;
  logic        a4_en;
  logic        a4_rdy;
  logic [23:0] a4_key;
  logic [7:0]  a4_pt_addr;
  logic [7:0]  a4_pt_wrdata;
  logic        a4_pt_wren;
  logic [7:0]  a4_pt_rddata;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;
  logic [7:0]  pt_rddata;

  modport master (
    input  en, stop, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata,
    output rdy, key_valid, key_out, a4_en, a4_key, a4_pt_rddata,
           pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, stop, a4_rdy, a4_pt_addr, a4_pt_wrdata, a4_pt_wren, pt_rddata,
    input  rdy, key_valid, key_out, a4_en, a4_key, a4_pt_rddata,
           pt_addr, pt_wrdata, pt_wren
  );
endinterface

`default_nettype wire

// File: rtl/pt_scan.sv
// ============================================================================
// Module   : pt_scan
// Brief    : Reads the length byte, then checks bytes 1..len for printable ASCII.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pt_scan
  import crack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       done,
  output logic       pass,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata
);

  localparam logic [2:0] c_st_idle     = ST_IDLE;
  localparam logic [2:0] c_st_rd_len   = ST_RD_LEN;
  localparam logic [2:0] c_st_wait_len = ST_WAIT_LEN;
  localparam logic [2:0] c_st_scan     = ST_SCAN;

  logic [2:0] r_state;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_chk_idx;
  logic       r_chk_valid;
  logic       w_byte_ok;
  logic       w_last;

  assign w_byte_ok = is_printable(pt_rddata);
  assign w_last    = (r_chk_idx == r_len);

  // r_chk_valid marks that pt_rddata holds the byte addressed one cycle earlier
  always_comb begin
    done    = 1'b0;
    pass    = 1'b0;
    pt_addr = LEN_ADDR;
    case (r_state)
      c_st_wait_len: begin
        if (pt_rddata == 8'd0) begin
          done = 1'b1;
          pass = 1'b1;
        end
      end
      c_st_scan: begin
        pt_addr = r_idx;
        if (r_chk_valid) begin
          if (!w_byte_ok) begin
            done = 1'b1;
          end else if (w_last) begin
            done = 1'b1;
            pass = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_chk_idx   <= 8'd0;
      r_chk_valid <= 1'b0;
    end else if (abort) begin
      r_state     <= c_st_idle;
      r_chk_valid <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) r_state <= c_st_rd_len;
        end
        c_st_rd_len: begin
          r_state <= c_st_wait_len;
        end
        c_st_wait_len: begin
          r_len       <= pt_rddata;
          r_idx       <= 8'd1;
          r_chk_idx   <= 8'd0;
          r_chk_valid <= 1'b0;
          r_state     <= (pt_rddata == 8'd0) ? c_st_idle : c_st_scan;
        end
        c_st_scan: begin
          if (done) begin
            r_state     <= c_st_idle;
            r_chk_valid <= 1'b0;
          end else begin
            r_chk_idx   <= r_idx;
            r_chk_valid <= 1'b1;
            r_idx       <= r_idx + 8'd1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/crack_ctrl.sv
// ============================================================================
// Module   : crack_ctrl
// Brief    : Key-search scheduler: steps keys, runs arc4, checks the plaintext.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crack_ctrl
  import crack_pkg::*;
#(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'd1,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  crack_ctrl_if.master      bus
);

  localparam logic [2:0] c_st_idle   = ST_IDLE;
  localparam logic [2:0] c_st_start  = ST_START;
  localparam logic [2:0] c_st_run    = ST_RUN;
  localparam logic [2:0] c_st_rd_len = ST_RD_LEN;
  localparam logic [2:0] c_st_next   = ST_NEXT;
  localparam logic [2:0] c_st_done   = ST_DONE;

  logic [2:0]  r_state;
  logic [23:0] r_a4_key;
  logic [23:0] r_key_out;
  logic        r_key_valid;
  logic        r_rdy;
  logic        r_a4_en;
  logic        r_seen_busy;
  logic        r_stop_latched;

  logic [24:0] w_next_key;
  logic        w_exhausted;
  logic        w_run;
  logic        w_scan_start;
  logic        w_scan_abort;
  logic        w_scan_done;
  logic        w_scan_pass;
  logic [7:0]  w_scan_addr;

  assign w_next_key  = {1'b0, r_a4_key} + {1'b0, KEY_STEP};
  assign w_exhausted = (w_next_key > {1'b0, KEY_LAST});
  assign w_run       = (r_state == c_st_run);

  assign w_scan_start = w_run && r_seen_busy && bus.a4_rdy
                        && !r_stop_latched && !bus.stop;
  assign w_scan_abort = (r_state == c_st_rd_len) && bus.stop;

  // Length read and byte scan; the top state stays RD_LEN until it reports done
  pt_scan u_pt_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_scan_start),
    .abort     (w_scan_abort),
    .done      (w_scan_done),
    .pass      (w_scan_pass),
    .pt_addr   (w_scan_addr),
    .pt_rddata (bus.pt_rddata)
  );

  assign bus.pt_addr      = w_run ? bus.a4_pt_addr : w_scan_addr;
  assign bus.pt_wrdata    = w_run ? bus.a4_pt_wrdata : 8'd0;
  assign bus.pt_wren      = w_run & bus.a4_pt_wren;
  assign bus.a4_pt_rddata = bus.pt_rddata;

  assign bus.rdy       = r_rdy;
  assign bus.key_valid = r_key_valid;
  assign bus.key_out   = r_key_out;
  assign bus.a4_en     = r_a4_en;
  assign bus.a4_key    = r_a4_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= c_st_idle;
      r_a4_key       <= KEY_START;
      r_key_out      <= 24'd0;
      r_key_valid    <= 1'b0;
      r_rdy          <= 1'b1;
      r_a4_en        <= 1'b0;
      r_seen_busy    <= 1'b0;
      r_stop_latched <= 1'b0;
    end else begin
      r_a4_en <= 1'b0;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (bus.en) begin
            r_a4_key       <= KEY_START;
            r_key_valid    <= 1'b0;
            r_rdy          <= 1'b0;
            r_stop_latched <= 1'b0;
            r_state        <= c_st_start;
          end
        end
        c_st_start: begin
          if (bus.stop) begin
            r_state     <= c_st_done;
            r_rdy       <= 1'b1;
            r_key_out   <= r_a4_key;
            r_key_valid <= 1'b0;
          end else if (bus.a4_rdy) begin
            r_a4_en     <= 1'b1;
            r_seen_busy <= 1'b0;
            r_state     <= c_st_run;
          end
        end
        c_st_run: begin
          // The core always finishes its run; a stop is only honoured afterwards
          if (bus.stop) r_stop_latched <= 1'b1;
          if (!bus.a4_rdy) r_seen_busy <= 1'b1;
          if (r_seen_busy && bus.a4_rdy) begin
            if (r_stop_latched || bus.stop) begin
              r_state     <= c_st_done;
              r_rdy       <= 1'b1;
              r_key_out   <= r_a4_key;
              r_key_valid <= 1'b0;
            end else begin
              r_state <= c_st_rd_len;
            end
          end
        end
        c_st_rd_len: begin
          if (bus.stop) begin
            r_state     <= c_st_done;
            r_rdy       <= 1'b1;
            r_key_out   <= r_a4_key;
            r_key_valid <= 1'b0;
          end else if (w_scan_done) begin
            if (w_scan_pass) begin
              r_state     <= c_st_done;
              r_rdy       <= 1'b1;
              r_key_out   <= r_a4_key;
              r_key_valid <= 1'b1;
            end else begin
              r_state <= c_st_next;
            end
          end
        end
        c_st_next: begin
          if (bus.stop || w_exhausted) begin
            r_state     <= c_st_done;
            r_rdy       <= 1'b1;
            r_key_out   <= r_a4_key;
            r_key_valid <= 1'b0;
          end else begin
            r_a4_key <= w_next_key[23:0];
            r_state  <= c_st_start;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire
